// File: rtl/tthbif_tx_arb.sv
// tthbif_tx_arb: frame-level round-robin arbiter sharing the tthbif TX link
// between NUM_REQ byte-stream requesters. Each granted frame is prefixed with a
// header byte carrying the requester index. A stall watchdog aborts a frame
// whose source goes quiet, emits ABORT_BYTE with last, then drains the source.
`timescale 1ns/1ps

module tthbif_tx_arb #(
    parameter int          NUM_REQ    = 2,
    parameter logic [7:0]  HDR_TAG    = 8'hA0,
    parameter logic [7:0]  ABORT_BYTE = 8'hFF,
    parameter int          TIMEOUT    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [NUM_REQ-1:0]     s_valid_i,
    input  logic [8*NUM_REQ-1:0]   s_data_i,
    input  logic [NUM_REQ-1:0]     s_last_i,
    output logic [NUM_REQ-1:0]     s_ready_o,
    output logic                   m_valid_o,
    output logic [7:0]             m_data_o,
    output logic                   m_last_o,
    input  logic                   m_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]      STALL_MAX = CW'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, ABORT, DRAIN} state_t;

    state_t             state, next_state;
    logic [IW-1:0]      g;          // granted requester index
    logic [IW-1:0]      rr_ptr;     // search start for the next grant
    logic [IW-1:0]      rr_next;
    logic [CW-1:0]      stall_cnt;
    logic [IW-1:0]      pick;
    logic               pick_found;
    int                 idx;
    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_data;
    logic [NUM_REQ-1:0] g_onehot;

    // Views of the granted requester's stream.
    assign g_valid  = s_valid_i[g];
    assign g_last   = s_last_i[g];
    assign g_data   = s_data_i[8*g +: 8];
    assign g_onehot = ONE << g;
    assign rr_next  = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && s_valid_i[idx]) begin
                pick_found = 1'b1;
                pick       = IW'(idx);
            end
        end
    end

    // State register; reset is asynchronous so outputs drop immediately.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (en_i && pick_found) next_state = HDR;
            HDR:   if (m_ready_i) next_state = DATA;
            DATA: begin
                if (g_valid && m_ready_i && g_last)        next_state = IDLE;
                else if (!g_valid && stall_cnt == STALL_MAX) next_state = ABORT;
            end
            ABORT: if (m_ready_i) next_state = DRAIN;
            DRAIN: if (g_valid && g_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant index, round-robin pointer and stall watchdog counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            g         <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == IDLE && next_state == HDR)
                g <= pick;
            if ((state == DATA || state == DRAIN) && next_state == IDLE)
                rr_ptr <= rr_next;
            // Only source silence counts; m_ready backpressure never does.
            if (state == DATA && !g_valid) stall_cnt <= stall_cnt + 1'b1;
            else                           stall_cnt <= '0;
        end
    end

    // Output decode from the current state.
    always_comb begin
        m_valid_o = 1'b0;
        m_data_o  = 8'h00;
        m_last_o  = 1'b0;
        s_ready_o = '0;
        grant_o   = (state == IDLE) ? '0 : g_onehot;
        busy_o    = (state != IDLE);
        timeout_o = 1'b0;
        case (state)
            HDR: begin
                m_valid_o = 1'b1;
                m_data_o  = HDR_TAG | 8'(g);
            end
            DATA: begin
                m_valid_o = g_valid;
                m_data_o  = g_data;
                m_last_o  = g_last;
                s_ready_o = m_ready_i ? g_onehot : '0;
                timeout_o = !g_valid && (stall_cnt == STALL_MAX);
            end
            ABORT: begin
                m_valid_o = 1'b1;
                m_data_o  = ABORT_BYTE;
                m_last_o  = 1'b1;
            end
            DRAIN: s_ready_o = g_onehot;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tthbif_tx_arb.sv
// Bench for tthbif_tx_arb: per-requester source drivers fed from byte queues,
// an expected-byte scoreboard filled as frames are issued, and a monitor that
// pops and compares on every transmitter-side transfer.
`timescale 1ns/1ps

module tb_tthbif_tx_arb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic [1:0]  grant;
    logic        busy;
    logic        tout;

    logic        v0, v1, l0, l1;
    logic [7:0]  d0, d1;
    logic        took0, took1;
    logic [8:0]  mon_e;

    assign s_valid = {v1, v0};
    assign s_data  = {d1, d0};
    assign s_last  = {l1, l0};

    // {last, data} entries
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tout_cnt = 0;
    int tout_cyc = 0;
    int c11 = 0;

    initial forever #5 clk = ~clk;

    tthbif_tx_arb #(
        .NUM_REQ(2), .HDR_TAG(8'hA0), .ABORT_BYTE(8'hFF), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
        .s_ready_o(s_ready),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last),
        .m_ready_i(m_ready),
        .grant_o(grant), .busy_o(busy), .timeout_o(tout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue a frame of n bytes (MSB-first in b) from requester k.
    task automatic send(input int k, input int n, input logic [31:0] b);
        logic [8:0] e;
        exp_q.push_back({1'b0, 8'hA0 | 8'(k)});
        for (int i = 0; i < n; i++) begin
            e = {(i == n - 1), b[8*(n-1-i) +: 8]};
            exp_q.push_back(e);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 20) begin step(); n++; end
        check({name, "_grant_wait"}, 32'(n < 20), 1);
    endtask

    task automatic wait_exp(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin step(); n++; end
        check({name, "_frames_done"}, 32'(n < 400), 1);
    endtask

    // Source driver for requester 0: presents the head of q0, pops on transfer.
    initial begin
        v0 = 1'b0; d0 = 8'h00; l0 = 1'b0;
        forever begin
            @(negedge clk);
            took0 = v0 && s_ready[0];
            @(posedge clk);
            #1;
            if (took0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin {l0, d0} = q0[0]; v0 = 1'b1; end
            else begin v0 = 1'b0; l0 = 1'b0; d0 = 8'h00; end
        end
    end

    // Source driver for requester 1.
    initial begin
        v1 = 1'b0; d1 = 8'h00; l1 = 1'b0;
        forever begin
            @(negedge clk);
            took1 = v1 && s_ready[1];
            @(posedge clk);
            #1;
            if (took1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin {l1, d1} = q1[0]; v1 = 1'b1; end
            else begin v1 = 1'b0; l1 = 1'b0; d1 = 8'h00; end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor on the transmitter side.
    initial forever begin
        @(negedge clk);
        if (!rst && m_valid && m_ready) begin
            if (m_data == 8'h11) c11 = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got %0h last=%0b expected no transfer", m_data, m_last);
            end else begin
                mon_e = exp_q.pop_front();
                check("m_byte", 32'({m_last, m_data}), 32'(mon_e));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && tout) begin
            tout_cnt++;
            tout_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int bad;
        int n;
        rst = 1'b1; en = 1'b1; m_ready = 1'b1;
        #12;
        check("reset_outs", 32'({m_valid, m_data, m_last, s_ready, grant, busy, tout}), 0);
        @(posedge clk); #2; rst = 1'b0;

        // 1: single frame from req0
        send(0, 3, 32'h112233);
        wait_busy("t1");
        check("t1_grant", 32'(grant), 32'h1);
        wait_exp("t1");
        check("t1_busy_after_last", 32'(busy), 0);

        // 2: both requesting after reset; round-robin then wrap
        @(posedge clk); #3; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        send(0, 2, 32'h0102);
        send(1, 2, 32'h0304);
        wait_exp("t2a");
        step();
        send(0, 1, 32'h05);
        send(1, 1, 32'h06);
        wait_exp("t2b");
        step();

        // 3: backpressure pattern and a long hold
        base = tout_cnt;
        send(0, 4, 32'h41424344);
        wait_busy("t3");
        step();                    // header accepted
        m_ready = 1'b0; step(); step();
        m_ready = 1'b1; step();    // 0x41 accepted
        m_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!(m_valid && m_data == 8'h42 && !m_last)) bad++;
        end
        check("t3_stable_bad_cycles", 32'(bad), 0);
        check("t3_src_held", 32'(q0.size()), 3);
        m_ready = 1'b1;
        wait_exp("t3");
        check("t3_no_timeout", 32'(tout_cnt - base), 0);
        step();

        // 4: watchdog abort after TO idle cycles, then drain
        base = tout_cnt;
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'hFF});
        q0.push_back({1'b0, 8'h11});
        n = 0;
        while (tout_cnt == base && n < 40) begin step(); n++; end
        check("t4_timeout_seen", 32'(n < 40), 1);
        check("t4_stall_cycles", 32'(tout_cyc - c11), TO);
        wait_exp("t4");
        q0.push_back({1'b0, 8'h44});
        q0.push_back({1'b1, 8'h55});
        n = 0;
        while ((q0.size() != 0 || busy) && n < 40) begin step(); n++; end
        check("t4_drained_idle", 32'(n < 40), 1);
        check("t4_single_pulse", 32'(tout_cnt - base), 1);
        step();

        // 5: en_i gating
        en = 1'b0;
        send(1, 2, 32'h7172);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant != 2'b00 || busy) bad++;
        end
        check("t5_no_grant_en0", 32'(bad), 0);
        check("t5_src_pending", 32'(q1.size()), 2);
        en = 1'b1;
        wait_exp("t5a");
        step();
        send(0, 3, 32'h818283);
        send(1, 1, 32'h91);
        wait_busy("t5b");
        en = 1'b0;
        n = 0;
        while ((q0.size() != 0 || busy) && n < 40) begin step(); n++; end
        check("t5_frame_completes", 32'(n < 40), 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant != 2'b00 || busy) bad++;
        end
        check("t5_no_new_grant", 32'(bad), 0);
        check("t5_req1_waiting", 32'(q1.size()), 1);
        en = 1'b1;
        wait_exp("t5c");
        step();

        // 6: asynchronous reset during DATA
        send(0, 3, 32'hA1A2A3);
        wait_busy("t6");
        step();                    // header accepted, now in DATA
        m_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("t6_async_reset", 32'({m_valid, m_data, m_last, s_ready, grant, busy, tout}), 0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        m_ready = 1'b1;
        send(0, 1, 32'hB0);
        send(1, 1, 32'hB1);
        wait_exp("t6");
        step(); step();
        check("end_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
